// File: rtl/nios2_mul_seq_ctrl.sv
// nios2_mul_seq_ctrl
//
// Multi-cycle multiply sequencer for the Nios II execute stage. One registered
// 16x16 unsigned multiplier cell is reused over successive cycles to build a
// 32x32 product from partial products, which are accumulated with their
// weights. For the high-word ops a signed correction is applied to the upper
// half of the accumulator before the result is returned.
//
// Build option:
//   NIOS2_MUL_SEQ_HIGH_EN  defined   : MUL/MULXUU/MULXSU/MULXSS, four partial
//                                      products, FIX state, 64-bit accumulator.
//                          undefined : every op is MUL, three partial products
//                                      (k3 never issued), no FIX, 32-bit acc.
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   cmd_valid  in   1   command present
//   cmd_ready  out  1   command accepted this cycle if cmd_valid (IDLE only)
//   cmd_src1   in  32   operand A
//   cmd_src2   in  32   operand B
//   cmd_op     in   2   00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   kill       in   1   abort the operation in flight
//   res_valid  out  1   res_data valid, held until accepted
//   res_ready  in   1   consumer accepts the result
//   res_data   out 32   result word
//   busy       out  1   high in every state except IDLE
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready high
// ISSUE  | one partial product per cycle into the multiplier (counter k)
// DRAIN  | last registered product added into the accumulator
// FIX    | signed correction of acc[63:32] (high-word build only)
// DONE   | result presented, waiting for res_ready

module nios2_mul_seq_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_src1,
    input  logic [31:0] cmd_src2,
    input  logic [1:0]  cmd_op,
    input  logic        kill,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b11;

`ifdef NIOS2_MUL_SEQ_HIGH_EN
    localparam int         ACC_W  = 64;
    localparam logic [1:0] K_LAST = 2'd3;
`else
    localparam int         ACC_W  = 32;
    localparam logic [1:0] K_LAST = 2'd2;
`endif

    state_t             state_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [ACC_W-1:0]   acc_q;
    logic [1:0]         k_q;
    logic [1:0]         last_k_q;
    logic [31:0]        prod_q;
    logic               cmd_ready_q;
    logic               busy_q;
    logic               res_valid_q;
    logic [31:0]        res_data_q;

`ifdef NIOS2_MUL_SEQ_HIGH_EN
    logic [1:0]         op_q;
    logic [31:0]        corr_a;
    logic [31:0]        corr_b;
    logic [31:0]        hi_fix;
`else
    // The op field has no meaning when only MUL is built.
    logic               unused_op;
    assign unused_op = ^cmd_op;
`endif

    logic               mul_en;
    logic [15:0]        mul_a;
    logic [15:0]        mul_b;
    logic [31:0]        mul_p;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   term;
    logic [ACC_W-1:0]   acc_sum;

    assign mul_en = (state_q == S_ISSUE) || (state_q == S_DRAIN);

    // k[1] picks the A half, k[0] picks the B half.
    assign mul_a = k_q[1] ? a_q[31:16] : a_q[15:0];
    assign mul_b = k_q[0] ? b_q[31:16] : b_q[15:0];
    assign mul_p = {16'h0000, mul_a} * {16'h0000, mul_b};

    // prod_q holds the product issued one cycle earlier; last_k_q remembers
    // which partial it was so the right weight is applied.
    always_comb begin
        prod_ext = ACC_W'(prod_q);
        term     = prod_ext;
        case (last_k_q)
            2'd1, 2'd2: term = prod_ext << 16;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
            2'd3:       term = prod_ext << 32;
`endif
            default:    term = prod_ext;
        endcase
    end

    assign acc_sum = acc_q + term;

`ifdef NIOS2_MUL_SEQ_HIGH_EN
    // Unsigned product of the raw bit patterns is off by B*2^32 when A is
    // negative and A*2^32 when B is negative; only the high word changes.
    assign corr_b = (op_q[1] && a_q[31])              ? b_q : 32'h0000_0000;
    assign corr_a = ((op_q == OP_MULXSS) && b_q[31])  ? a_q : 32'h0000_0000;
    assign hi_fix = acc_q[63:32] - corr_b - corr_a;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            last_k_q    <= '0;
            prod_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
            op_q        <= OP_MUL;
`endif
        end else begin
            if (mul_en) begin
                prod_q <= mul_p;
            end

            if (kill && (state_q != S_IDLE)) begin
                state_q     <= S_IDLE;
                cmd_ready_q <= 1'b1;
                busy_q      <= 1'b0;
                res_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            a_q         <= cmd_src1;
                            b_q         <= cmd_src2;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
                            op_q        <= cmd_op;
`endif
                            acc_q       <= '0;
                            k_q         <= 2'd0;
                            state_q     <= S_ISSUE;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end

                    S_ISSUE: begin
                        // Nothing is in the multiplier yet on the k0 cycle.
                        if (k_q != 2'd0) begin
                            acc_q <= acc_sum;
                        end
                        last_k_q <= k_q;
                        k_q      <= k_q + 2'd1;
                        if (k_q == K_LAST) begin
                            state_q <= S_DRAIN;
                        end
                    end

                    S_DRAIN: begin
                        acc_q <= acc_sum;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
                        state_q <= S_FIX;
`else
                        state_q     <= S_DONE;
                        res_valid_q <= 1'b1;
                        res_data_q  <= acc_sum[31:0];
`endif
                    end

`ifdef NIOS2_MUL_SEQ_HIGH_EN
                    S_FIX: begin
                        acc_q[63:32] <= hi_fix;
                        res_data_q   <= (op_q == OP_MUL) ? acc_q[31:0] : hi_fix;
                        res_valid_q  <= 1'b1;
                        state_q      <= S_DONE;
                    end
`endif

                    S_DONE: begin
                        if (res_ready) begin
                            state_q     <= S_IDLE;
                            res_valid_q <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end

                    default: begin
                        state_q     <= S_IDLE;
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_nios2_mul_seq_ctrl.sv
module tb_nios2_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_src1;
    logic [31:0] cmd_src2;
    logic [1:0]  cmd_op;
    logic        kill;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];

`ifdef NIOS2_MUL_SEQ_HIGH_EN
    localparam int LAT     = 6;
    localparam bit HIGH_EN = 1'b1;
`else
    localparam int LAT     = 4;
    localparam bit HIGH_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    nios2_mul_seq_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src1  (cmd_src1),
        .cmd_src2  (cmd_src2),
        .cmd_op    (cmd_op),
        .kill      (kill),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        logic [63:0] p;
        case (op)
            2'b10:   p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b});
            2'b11:   p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            default: p = {32'h0, a} * {32'h0, b};
        endcase
        if (!HIGH_EN || op == 2'b00) begin
            p = {32'h0, a} * {32'h0, b};
            return p[31:0];
        end
        return p[63:32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                            input bit push, input logic [31:0] exp, output bit ok);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_src1  = a;
        cmd_src2  = b;
        cmd_op    = op;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (cmd_ready) begin
            tick();
            ok = 1'b1;
            if (push) exp_q.push_back(exp);
        end else begin
            ok = 1'b0;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output bit seen);
        lat = 0;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        seen = res_valid;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_src1  = '0;
        cmd_src2  = '0;
        cmd_op    = 2'b00;
        kill      = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        n_vec++; if (cmd_ready !== 1'b1) begin n_miss++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (res_data !== 32'h0) begin n_miss++; $display("FAIL reset_res_data: got %h expected 00000000", res_data); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_mul_max();
        bit ok, seen;
        int lat;
        logic [31:0] exp;
        send_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1, 32'h0000_0001, ok);
        n_vec++; if (!ok) begin n_miss++; $display("FAIL mul_max_accept: got not accepted expected accepted"); end
        n_vec++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_miss++; $display("FAIL mul_max_busy: got busy=%b ready=%b expected busy=1 ready=0", busy, cmd_ready); end
        wait_result(lat, seen);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_vec++; if (!seen) begin n_miss++; $display("FAIL mul_max_timeout: got no res_valid expected res_valid"); end
        n_vec++; if (lat != LAT) begin n_miss++; $display("FAIL mul_max_latency: got %0d expected %0d", lat, LAT); end
        n_vec++; if (res_data !== exp) begin n_miss++; $display("FAIL mul_max_data: got %h expected %h", res_data, exp); end
        consume();
        n_vec++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_miss++; $display("FAIL mul_max_idle: got busy=%b valid=%b expected 0 0", busy, res_valid); end
    endtask

    task automatic test_ops();
        logic [31:0] ta[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0001_0000};
        logic [1:0]  to[5] = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b00};
`ifdef NIOS2_MUL_SEQ_HIGH_EN
        logic [31:0] te[5] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
`else
        logic [31:0] te[5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
`endif
        for (int i = 0; i < 5; i++) begin
            bit ok, seen;
            int lat;
            logic [31:0] exp;
            send_cmd(ta[i], ta[i], to[i], 1'b1, te[i], ok);
            wait_result(lat, seen);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            n_vec++;
            if (!ok || !seen || res_data !== exp) begin
                n_miss++;
                $display("FAIL ops_%0d op=%b: got %h (ok=%b seen=%b) expected %h", i, to[i], res_data, ok, seen, exp);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        bit ok, seen;
        int lat;
        logic [31:0] exp;
        send_cmd(32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 1'b1, model(32'h1234_5678, 32'h9ABC_DEF0, 2'b00), ok);
        wait_result(lat, seen);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_vec++; if (!seen) begin n_miss++; $display("FAIL bp_timeout: got no res_valid expected res_valid"); end
        cmd_valid = 1'b1;
        cmd_src1  = 32'h0000_0007;
        cmd_src2  = 32'h0000_0009;
        cmd_op    = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (res_valid !== 1'b1 || res_data !== exp || cmd_ready !== 1'b0) begin
                n_miss++;
                $display("FAIL bp_hold_%0d: got valid=%b data=%h ready=%b expected 1 %h 0", i, res_valid, res_data, cmd_ready, exp);
            end
        end
        cmd_valid = 1'b0;
        consume();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (busy !== 1'b0 || res_valid !== 1'b0) begin
                n_miss++;
                $display("FAIL bp_no_capture_%0d: got busy=%b valid=%b expected 0 0", i, busy, res_valid);
            end
            tick();
        end
    endtask

    task automatic test_kill();
        bit ok, seen, leaked;
        int lat;
        logic [31:0] exp;
        send_cmd(32'h0000_DEAD, 32'h0000_BEEF, 2'b00, 1'b0, 32'h0, ok);
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL kill_issue: got busy=%b ready=%b valid=%b expected 0 1 0", busy, cmd_ready, res_valid);
        end
        leaked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (res_valid !== 1'b0) leaked = 1'b1;
        end
        n_vec++; if (leaked) begin n_miss++; $display("FAIL kill_no_result: got res_valid=1 expected 0"); end
        send_cmd(32'd3, 32'd5, 2'b00, 1'b1, 32'h0000_000F, ok);
        wait_result(lat, seen);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_vec++; if (!seen || res_data !== exp) begin n_miss++; $display("FAIL kill_next: got %h (seen=%b) expected %h", res_data, seen, exp); end
        consume();

        // kill together with res_ready in DONE discards the result
        send_cmd(32'd6, 32'd7, 2'b00, 1'b0, 32'h0, ok);
        wait_result(lat, seen);
        kill      = 1'b1;
        res_ready = 1'b1;
        tick();
        kill      = 1'b0;
        res_ready = 1'b0;
        n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_miss++; $display("FAIL kill_done: got valid=%b busy=%b expected 0 0", res_valid, busy); end

        // kill in IDLE does not block acceptance
        kill = 1'b1;
        send_cmd(32'd11, 32'd13, 2'b00, 1'b1, 32'd143, ok);
        kill = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL kill_idle: got busy=%b expected 1", busy); end
        wait_result(lat, seen);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_vec++; if (!seen || res_data !== exp) begin n_miss++; $display("FAIL kill_idle_data: got %h expected %h", res_data, exp); end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_cmd(32'hAAAA_5555, 32'h1357_9BDF, 2'b00, 1'b0, 32'h0, ok);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 32'h0) begin
            n_miss++;
            $display("FAIL reset_mid: got ready=%b busy=%b valid=%b data=%h expected 1 0 0 00000000", cmd_ready, busy, res_valid, res_data);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bit ok, seen;
            int lat;
            logic [31:0] a, b, exp;
            logic [1:0] op;
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
            if (i == 0) begin a = 32'h8000_0000; b = 32'h0000_0002; op = 2'b10; end
            if (i == 1) begin a = 32'h7FFF_FFFF; b = 32'h8000_0001; op = 2'b11; end
            send_cmd(a, b, op, 1'b1, model(a, b, op), ok);
            wait_result(lat, seen);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            n_vec++;
            if (!ok || !seen || res_data !== exp) begin
                n_miss++;
                $display("FAIL b2b_%0d a=%h b=%h op=%b: got %h expected %h", i, a, b, op, res_data, exp);
            end
            tick();
            n_vec++; if (cmd_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, cmd_ready); end
        end
        res_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mul_max();
        test_ops();
        test_backpressure();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
